my_dispatch8: RTL and testbench

- Round-robin write dispatcher that shares one producer stream among 8 consumer lanes.
- Holds one word in a 1-entry buffer and steers it to the current lane with a one-hot strobe, using the existing 8-way demultiplexer.
- Skips disabled lanes and waits on the selected lane's ready.
- Sits in front of 8-register banks or 8 peripheral sinks.

---
 rtl/my_dispatch8_pkg.sv | 27 ++
 rtl/my_dispatch8_rr.sv | 15 +
 rtl/my_dmux8way.sv | 24 ++
 rtl/my_dispatch8.sv | 72 +++++++
 tb/tb_my_dispatch8.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/my_dispatch8_pkg.sv
// Shared lane constants and the rotate-priority lane search for the 8-lane dispatcher.
package my_dispatch8_pkg;

    localparam int LANES = 8;
    localparam int SEL_W = 3;

    typedef logic [SEL_W-1:0] lane_idx_t;
    typedef logic [LANES-1:0] lane_mask_t;

    // First enabled lane after start (start+1 .. start+7), optionally wrapping onto start itself.
    // Returns start when nothing qualifies, so the caller's pointer simply holds.
    function automatic lane_idx_t next_en(input lane_mask_t mask, input lane_idx_t start,
                                          input logic incl_self);
        lane_idx_t idx;
        logic      found;
        next_en = start;
        found   = 1'b0;
        for (int k = 1; k <= LANES; k++) begin
            idx = start + lane_idx_t'(k);
            if (!found && mask[idx] && ((k < LANES) || incl_self)) begin
                next_en = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/my_dispatch8_rr.sv
// Combinational rotate-priority search over an 8-bit lane mask.
module my_rr_next8
    import my_dispatch8_pkg::*;
(
    input  logic [7:0] mask_i,
    input  logic [2:0] start_i,
    input  logic       incl_self_i,
    output logic [2:0] idx_o
);

    always_comb begin
        idx_o = next_en(mask_i, start_i, incl_self_i);
    end

endmodule

// File: rtl/my_dmux8way.sv
// 1-to-8 demultiplexer: input a appears on the output selected by sel, all others low.
module my_dmux8way (
    input  logic       a,
    input  logic [2:0] sel,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       h,
    output logic       i
);

    assign b = a & (sel == 3'd0);
    assign c = a & (sel == 3'd1);
    assign d = a & (sel == 3'd2);
    assign e = a & (sel == 3'd3);
    assign f = a & (sel == 3'd4);
    assign g = a & (sel == 3'd5);
    assign h = a & (sel == 3'd6);
    assign i = a & (sel == 3'd7);

endmodule

// File: rtl/my_dispatch8.sv
// Round-robin write dispatcher: one-entry buffer steering each word to the next enabled lane.
module my_dispatch8
    import my_dispatch8_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [7:0]       lane_en,
    input  logic [7:0]       out_ready,
    output logic [7:0]       out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       sel
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;
    lane_idx_t        sel_q, sel_d;
    lane_idx_t        nxt_sel;
    logic             lane_ok, fire_out, fire_in;

    assign lane_ok  = lane_en[sel_q];
    assign fire_out = full_q & lane_ok & out_ready[sel_q];
    assign in_ready = ~full_q | fire_out;
    assign fire_in  = in_valid & in_ready;

    assign sel      = sel_q;
    assign out_data = data_q;

    // A disabled current lane never matches itself, so one search covers dispatch and re-steer.
    my_rr_next8 u_rr (
        .mask_i      (lane_en),
        .start_i     (sel_q),
        .incl_self_i (fire_out),
        .idx_o       (nxt_sel)
    );

    my_dmux8way u_dmux (
        .a   (full_q & lane_ok),
        .sel (sel_q),
        .b   (out_valid[0]),
        .c   (out_valid[1]),
        .d   (out_valid[2]),
        .e   (out_valid[3]),
        .f   (out_valid[4]),
        .g   (out_valid[5]),
        .h   (out_valid[6]),
        .i   (out_valid[7])
    );

    always_comb begin
        full_d = fire_in | (full_q & ~fire_out);
        data_d = fire_in ? in_data : data_q;
        sel_d  = (fire_out | ~lane_ok) ? nxt_sel : sel_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
            sel_q  <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            sel_q  <= sel_d;
        end
    end

endmodule

// File: tb/tb_my_dispatch8.sv
// Directed bench for my_dispatch8: vector table plus hand-written multi-cycle sequences.
module tb_my_dispatch8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [7:0]  lane_en;
    logic [7:0]  out_ready;
    logic [7:0]  out_valid;
    logic [15:0] out_data;
    logic [2:0]  sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    my_dispatch8 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .lane_en   (lane_en),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sel       (sel)
    );

    typedef struct {
        logic        rst_n;
        logic        iv;
        logic [15:0] d;
        logic [7:0]  en;
        logic [7:0]  rdy;
        logic        chk;
        logic        ir;
        logic [7:0]  ov;
        logic [15:0] od;
        logic [2:0]  sel;
    } vec_t;

    vec_t vecs[64];
    int   nvec = 0;

    task automatic add(input logic r, input logic iv, input logic [15:0] d, input logic [7:0] en,
                       input logic [7:0] rdy, input logic chk, input logic ir, input logic [7:0] ov,
                       input logic [15:0] od, input logic [2:0] s);
        vecs[nvec] = '{r, iv, d, en, rdy, chk, ir, ov, od, s};
        nvec++;
    endtask

    // Drive on the falling edge; outputs are compared 1 time unit later, before the next rising edge.
    task automatic drive(input logic r, input logic iv, input logic [15:0] d, input logic [7:0] en,
                         input logic [7:0] rdy);
        @(negedge clk);
        rst_n     = r;
        in_valid  = iv;
        in_data   = d;
        lane_en   = en;
        out_ready = rdy;
        #1;
    endtask

    task automatic expect_out(input string name, input logic ir, input logic [7:0] ov,
                              input logic [15:0] od, input logic [2:0] s);
        checks++;
        if (in_ready !== ir) begin
            errors++;
            $display("FAIL %s in_ready got %b want %b", name, in_ready, ir);
        end
        checks++;
        if (out_valid !== ov) begin
            errors++;
            $display("FAIL %s out_valid got %h want %h", name, out_valid, ov);
        end
        checks++;
        if (out_data !== od) begin
            errors++;
            $display("FAIL %s out_data got %h want %h", name, out_data, od);
        end
        checks++;
        if (sel !== s) begin
            errors++;
            $display("FAIL %s sel got %0d want %0d", name, sel, s);
        end
    endtask

    initial begin
        string nm;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; lane_en = 8'hFF; out_ready = 8'hFF;

        // Reset with a pending producer word: nothing accepted or dispatched.
        add(0, 1, 16'h1234, 8'hFF, 8'hFF, 0, 1, 8'h00, 16'h0000, 3'd0);
        add(0, 1, 16'h1234, 8'hFF, 8'hFF, 1, 1, 8'h00, 16'h0000, 3'd0);
        add(1, 0, 16'h1234, 8'hFF, 8'hFF, 1, 1, 8'h00, 16'h0000, 3'd0);
        // Streaming: ten back-to-back words across all lanes.
        add(1, 1, 16'hA000, 8'hFF, 8'hFF, 1, 1, 8'h00, 16'h0000, 3'd0);
        for (int k = 1; k <= 9; k++)
            add(1, 1, 16'hA000 + 16'(k), 8'hFF, 8'hFF, 1, 1, 8'(1 << ((k - 1) % 8)),
                16'hA000 + 16'(k - 1), 3'((k - 1) % 8));
        add(1, 0, 16'h0000, 8'hFF, 8'hFF, 1, 1, 8'h02, 16'hA009, 3'd1);
        add(1, 0, 16'h0000, 8'hFF, 8'hFF, 1, 1, 8'h00, 16'hA009, 3'd2);
        // Sparse mask 0010_0100 from reset.
        add(0, 0, 16'h0000, 8'h24, 8'hFF, 1, 1, 8'h00, 16'hA009, 3'd2);
        add(1, 0, 16'h0000, 8'h24, 8'hFF, 1, 1, 8'h00, 16'h0000, 3'd0);
        add(1, 1, 16'hB001, 8'h24, 8'hFF, 1, 1, 8'h00, 16'h0000, 3'd2);
        add(1, 1, 16'hB002, 8'h24, 8'hFF, 1, 1, 8'h04, 16'hB001, 3'd2);
        add(1, 1, 16'hB003, 8'h24, 8'hFF, 1, 1, 8'h20, 16'hB002, 3'd5);
        add(1, 0, 16'h0000, 8'h24, 8'hFF, 1, 1, 8'h04, 16'hB003, 3'd2);
        add(1, 0, 16'h0000, 8'h24, 8'hFF, 1, 1, 8'h00, 16'hB003, 3'd5);

        for (int v = 0; v < nvec; v++) begin
            drive(vecs[v].rst_n, vecs[v].iv, vecs[v].d, vecs[v].en, vecs[v].rdy);
            if (vecs[v].chk) begin
                nm = $sformatf("vec%0d", v);
                expect_out(nm, vecs[v].ir, vecs[v].ov, vecs[v].od, vecs[v].sel);
            end
        end

        // Backpressure on lane 0.
        drive(0, 0, 16'h0000, 8'hFF, 8'hFF);
        drive(1, 1, 16'hC000, 8'hFF, 8'hFE);
        expect_out("bp_accept", 1, 8'h00, 16'h0000, 3'd0);
        for (int k = 0; k < 5; k++) begin
            drive(1, 1, 16'hC001, 8'hFF, 8'hFE);
            expect_out($sformatf("bp_hold%0d", k), 0, 8'h01, 16'hC000, 3'd0);
        end
        drive(1, 1, 16'hC001, 8'hFF, 8'hFF);
        expect_out("bp_release", 1, 8'h01, 16'hC000, 3'd0);
        drive(1, 0, 16'h0000, 8'hFF, 8'hFF);
        expect_out("bp_next", 1, 8'h02, 16'hC001, 3'd1);

        // Re-steer a word held on lane 3 after lane 3 is disabled.
        drive(1, 1, 16'hD000, 8'hF8, 8'h00);
        expect_out("rs_accept", 1, 8'h00, 16'hC001, 3'd2);
        drive(1, 0, 16'h0000, 8'hF8, 8'h00);
        expect_out("rs_held3", 0, 8'h08, 16'hD000, 3'd3);
        drive(1, 0, 16'h0000, 8'hF0, 8'h00);
        expect_out("rs_drop3", 0, 8'h00, 16'hD000, 3'd3);
        drive(1, 0, 16'h0000, 8'hF0, 8'h00);
        expect_out("rs_lane4", 0, 8'h10, 16'hD000, 3'd4);
        drive(1, 0, 16'h0000, 8'hF8, 8'hFF);
        expect_out("rs_fire4", 1, 8'h10, 16'hD000, 3'd4);
        drive(1, 0, 16'h0000, 8'hFF, 8'h00);
        expect_out("rs_after", 1, 8'h00, 16'hD000, 3'd5);

        // All lanes disabled while full, then only lane 7 restored.
        drive(1, 1, 16'hE000, 8'hFF, 8'h00);
        expect_out("dis_accept", 1, 8'h00, 16'hD000, 3'd5);
        for (int k = 0; k < 2; k++) begin
            drive(1, 1, 16'hE0FF, 8'h00, 8'hFF);
            expect_out($sformatf("dis_off%0d", k), 0, 8'h00, 16'hE000, 3'd5);
        end
        drive(1, 0, 16'h0000, 8'h80, 8'h00);
        expect_out("dis_restore", 0, 8'h00, 16'hE000, 3'd5);
        drive(1, 0, 16'h0000, 8'h80, 8'h00);
        expect_out("dis_lane7", 0, 8'h80, 16'hE000, 3'd7);
        drive(1, 0, 16'h0000, 8'h80, 8'hFF);
        expect_out("dis_fire7", 1, 8'h80, 16'hE000, 3'd7);
        drive(1, 1, 16'hE001, 8'h80, 8'h00);
        expect_out("dis_refill", 1, 8'h00, 16'hE000, 3'd7);
        drive(0, 0, 16'h0000, 8'h80, 8'h00);
        expect_out("rst_full", 0, 8'h80, 16'hE001, 3'd7);
        drive(0, 1, 16'h5555, 8'h80, 8'hFF);
        expect_out("rst_cleared", 1, 8'h00, 16'h0000, 3'd0);
        drive(1, 0, 16'h0000, 8'h80, 8'hFF);
        expect_out("rst_release", 1, 8'h00, 16'h0000, 3'd0);
        drive(1, 0, 16'h0000, 8'h80, 8'hFF);
        expect_out("rst_nodisp", 1, 8'h00, 16'h0000, 3'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
